// File: rtl/countdown_timer.sv
// Loadable 8-bit down-counter with prescaler, run/pause/done control FSM and
// two active-low seven-segment digit outputs.
module countdown_timer #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk_i,
  input  logic       clear_b_i,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  input  logic       start_i,
  input  logic       pause_i,
  output logic [7:0] count_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [6:0] hex0_o,
  output logic [6:0] hex1_o
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      count_q, count_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            done_q, done_d;
  logic            advance;

  always_ff @(posedge clk_i or negedge clear_b_i) begin
    if (!clear_b_i) begin
      state_q <= StIdle;
      count_q <= 8'h00;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    advance = 1'b0;
    if (load_i) begin
      count_d = load_value_i;
      pre_d   = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (count_q != 8'h00) begin
              state_d = StRun;
              pre_d   = '0;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StRun: begin
          if (pause_i) state_d = StPaused;
          else         advance = 1'b1;
        end
        // The resume edge counts, so a pause costs exactly one clock per high cycle.
        StPaused: begin
          if (!pause_i) begin
            state_d = StRun;
            advance = 1'b1;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase

      if (advance) begin
        if (pre_q == PreMax) begin
          pre_d   = '0;
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign count_o = count_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == StRun) || (state_q == StPaused);
  assign hex0_o  = seg7(count_q[3:0]);
  assign hex1_o  = seg7(count_q[7:4]);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: PRESCALE=4 instance plus a PRESCALE=1
// instance for the single-cycle-tick case.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       clear_b;
  logic       load, start, pause;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       busy, done;
  logic [6:0] hex0, hex1;

  logic       load1, start1;
  logic [7:0] load_value1;
  logic [7:0] count1;
  logic       busy1, done1;
  logic [6:0] hex0_1, hex1_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  countdown_timer #(.PRESCALE(4)) dut (
    .clk_i       (clk),
    .clear_b_i   (clear_b),
    .load_i      (load),
    .load_value_i(load_value),
    .start_i     (start),
    .pause_i     (pause),
    .count_o     (count),
    .busy_o      (busy),
    .done_o      (done),
    .hex0_o      (hex0),
    .hex1_o      (hex1)
  );

  countdown_timer #(.PRESCALE(1)) dut1 (
    .clk_i       (clk),
    .clear_b_i   (clear_b),
    .load_i      (load1),
    .load_value_i(load_value1),
    .start_i     (start1),
    .pause_i     (1'b0),
    .count_o     (count1),
    .busy_o      (busy1),
    .done_o      (done1),
    .hex0_o      (hex0_1),
    .hex1_o      (hex1_1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_b = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_value = 8'h00;
    load1 = 1'b0; start1 = 1'b0; load_value1 = 8'h00;
    #3;
    chk("rst_count", count, 8'h00);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_hex0", 8'(hex0), 8'h40);
    chk("rst_hex1", 8'(hex1), 8'h40);
    #9 clear_b = 1'b1;
    tick();

    // Basic run: load 3, start at edge k.
    load = 1'b1; load_value = 8'h03; tick();
    chk("load3_count", count, 8'h03);
    load = 1'b0; start = 1'b1; tick();
    chk("run_busy_k", 8'(busy), 8'd1);
    chk("run_count_k", count, 8'h03);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("run_count", count, 8'(3 - i / 4));
      chk("run_done", 8'(done), 8'(i == 12));
      chk("run_busy", 8'(busy), 8'(i < 12));
    end
    tick();
    chk("run_done_gone", 8'(done), 8'd0);
    chk("run_count_hold", count, 8'h00);
    start = 1'b1; tick(); start = 1'b0;
    chk("done_start_ignored", 8'(done), 8'd0);

    // Pause: load 2, start at k, pause high for edges k+2..k+6.
    load = 1'b1; load_value = 8'h02; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    pause = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk("pause_busy", 8'(busy), 8'd1);
      chk("pause_count", count, 8'h02);
    end
    pause = 1'b0;
    tick(); tick();
    chk("pause_k8", count, 8'h02);
    tick();
    chk("pause_k9", count, 8'h01);
    tick(); tick(); tick();
    chk("pause_k12", count, 8'h01);
    chk("pause_k12_done", 8'(done), 8'd0);
    tick();
    chk("pause_k13", count, 8'h00);
    chk("pause_k13_done", 8'(done), 8'd1);

    // Zero start.
    load = 1'b1; load_value = 8'h00; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("zero_done", 8'(done), 8'd1);
    chk("zero_busy", 8'(busy), 8'd0);
    tick();
    chk("zero_done_once", 8'(done), 8'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("zero_restart", 8'(done), 8'd0);
    tick();
    chk("zero_restart2", 8'(done), 8'd0);
    chk("zero_count", count, 8'h00);

    // Load abort at count 5.
    load = 1'b1; load_value = 8'h06; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("abort_pre", count, 8'h05);
    load = 1'b1; load_value = 8'hA1; tick(); load = 1'b0;
    chk("abort_count", count, 8'hA1);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_hex1", 8'(hex1), 8'h08);
    chk("abort_hex0", 8'(hex0), 8'h79);
    repeat (5) tick();
    chk("abort_hold", count, 8'hA1);

    // Load and start together: load wins, stays idle.
    load = 1'b1; start = 1'b1; load_value = 8'h8F; tick();
    load = 1'b0; start = 1'b0;
    chk("simul_busy", 8'(busy), 8'd0);
    repeat (6) tick();
    chk("simul_count", count, 8'h8F);
    chk("simul_hex1", 8'(hex1), 8'h00);
    chk("simul_hex0", 8'(hex0), 8'h0E);

    // Asynchronous reset mid-run with count 0x37.
    load = 1'b1; load_value = 8'h37; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("prerst_busy", 8'(busy), 8'd1);
    clear_b = 1'b0;
    #1;
    chk("arst_count", count, 8'h00);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_done", 8'(done), 8'd0);
    chk("arst_hex0", 8'(hex0), 8'h40);
    chk("arst_hex1", 8'(hex1), 8'h40);
    #2 clear_b = 1'b1;
    tick();
    chk("postrst_busy", 8'(busy), 8'd0);
    chk("postrst_count", count, 8'h00);

    // PRESCALE=1 instance: 0xFF expires after exactly 255 RUN edges.
    load1 = 1'b1; load_value1 = 8'hFF; tick(); load1 = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("p1_start", count1, 8'hFF);
    tick();
    chk("p1_first", count1, 8'hFE);
    tick();
    chk("p1_second", count1, 8'hFD);
    repeat (252) tick();
    chk("p1_254", count1, 8'h01);
    chk("p1_254_done", 8'(done1), 8'd0);
    chk("p1_254_busy", 8'(busy1), 8'd1);
    tick();
    chk("p1_255", count1, 8'h00);
    chk("p1_255_done", 8'(done1), 8'd1);
    chk("p1_255_busy", 8'(busy1), 8'd0);
    tick();
    chk("p1_after", 8'(done1), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable 8-bit down-counter with a programmable prescaler and a four-state control FSM. It is the count-down counterpart of the up-counting display chain. Software-visible inputs come from switches/keys. The current count is shown on two active-low seven-segment digits. A one-cycle `done` pulse marks expiry for downstream logic.

## Interface
- `PRESCALE`, default 4: clock cycles per decrement. Legal range is 1..2^26. Board builds use 50_000_000. The prescaler counter width is `$clog2(PRESCALE)`, minimum 1.
- `clk` input, 1 bit: single clock. All state changes on its rising edge.
- `clear_b` input, 1 bit: asynchronous, active-low reset.
- `load` input, 1 bit: synchronous load of `load_value`.
- `load_value` input, 8 bits: unsigned start count.
- `start` input, 1 bit: level-sampled run request.
- `pause` input, 1 bit: level; freezes counting while high.
- `count` output, 8 bits: current count, registered.
- `busy` output, 1 bit: high in RUN or PAUSED.
- `done` output, 1 bit: one-cycle expiry pulse, registered.
- `HEX0` output, 7 bits: segments for `count[3:0]`.
- `HEX1` output, 7 bits: segments for `count[7:4]`.

## Operation
- **Reset** (`clear_b`=0, immediate, independent of `clk`):
  - state IDLE, `count`=0x00, prescaler=0, `done`=0, `busy`=0.
  - `HEX0` and `HEX1` = 7'b1000000 (digit 0).
- **States:** IDLE, RUN, PAUSED, DONE. `busy` = (state==RUN || state==PAUSED).
- **Priority per edge:** `load` > `start` > `pause` > counting.
- **`load`**, in any state:
  - `count`←`load_value`, prescaler←0, state←IDLE, `done`←0.
  - Aborts a run in progress.
- **IDLE:**
  - `start`=1 and `count`≠0 → RUN, prescaler←0.
  - `start`=1 and `count`==0 → DONE, with `done`=1 for one cycle.
  - Otherwise hold.
- **RUN:**
  - `pause`=1 → PAUSED. This edge does not advance the prescaler or `count`.
  - Otherwise, if prescaler==PRESCALE-1: prescaler←0 and `count`←`count`-1.
    - If the old `count` was 1, state←DONE and `done`←1.
  - Otherwise prescaler←prescaler+1.
- **PAUSED:**
  - Prescaler and `count` frozen.
  - `pause`=0 → RUN. Counting resumes from the frozen prescaler value, so no tick is lost or gained.
- **DONE:**
  - `count` holds 0x00; `done` is low after its single pulse cycle.
  - `start` and `pause` are ignored. Only `load` or reset exits.
- **`start` while RUN or PAUSED:** ignored; it does not restart the prescaler.
- **Arithmetic:** unsigned 8-bit. `count` never wraps below 0, because the FSM leaves RUN at 0.
- **Segment encoding** (combinational from `count`):
  - Active-low. Bit 0=a … bit 6=g.
  - Hex digits 0–F, same glyphs as the team's display decoder. Examples: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.

## Timing
- `start` sampled at edge k puts the FSM in RUN after k.
- The first decrement is at edge k+PRESCALE; each later decrement is every PRESCALE edges.
- With load value N≥1 and no pause, `count` reaches 0 at edge k+N·PRESCALE. `done` is high for exactly the cycle following that edge, coincident with `count`==0 first appearing.
- Each pause cycle in RUN or PAUSED delays expiry by exactly one clock per cycle `pause` is high.
- PRESCALE=1 decrements on every RUN edge. This is legal and must not skip or double-count.
- `HEX0` and `HEX1` are combinational from registered `count`, with no extra latency.
- Reset asserted mid-run clears everything asynchronously. On release, the first rising edge behaves as IDLE.
- `load` and `start` both high in one cycle: load wins and the state is IDLE. `start` must be re-asserted on a later cycle.

## Test plan
All scenarios use PRESCALE=4.
- **Reset:** drive `clear_b`=0 mid-run with `count`=0x37 → `count`=0x00, `busy`=0, `done`=0, `HEX0`=`HEX1`=1000000 before the next edge.
- **Basic run:** load 0x03, pulse `start` at edge k → `count`=2,1,0 at edges k+4, k+8, k+12. `done`=1 only during the cycle after k+12; `busy` falls at k+12.
- **Pause:** load 0x02, start, hold `pause` for 5 cycles starting 2 cycles in → `count` reaches 0 at edge k+8+5. Prescaler phase is preserved across the pause.
- **Zero start:** load 0x00, start → state DONE, a single `done` pulse, `count` stays 0. A later `start` produces no further pulse.
- **Load abort:** during a run at `count`=0x05, assert `load` with 0xA1 → `count`=0xA1, `busy`=0, no `done`. `HEX1`=0001000, `HEX0`=1111001.
- **Simultaneous and PRESCALE=1:** `load`+`start` in the same cycle → IDLE with no counting. A PRESCALE=1 instance loaded with 0xFF expires in exactly 255 RUN edges.
